// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
// Holds the FSM state encoding and the operand/product widths.
package mult_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RESULT
    } state_t;

    localparam int MUL_W       = 8;
    localparam int PROD_W      = 16;
    localparam int MUL_LAT     = 8;
    // A few cycles of slack beyond the multiplier's nominal latency.
    localparam int DEF_TIMEOUT = MUL_LAT + 4;

endpackage

// File: rtl/mult_sched_if.sv
// Request, result and multiplier-side signals of the scheduler.
// The slave modport is the scheduler's view, master is the environment's.
interface mult_sched_if #(
    parameter int N_REQ = 4
) ();
    import mult_sched_pkg::*;

    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [MUL_W*N_REQ-1:0] req_a;
    logic [MUL_W*N_REQ-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;

    logic                   res_valid;
    logic                   res_ready;
    logic [ID_W-1:0]        res_id;
    logic [PROD_W-1:0]      res_product;
    logic                   res_err;

    logic                   mul_start;
    logic [MUL_W-1:0]       mul_a;
    logic [MUL_W-1:0]       mul_b;
    logic [PROD_W-1:0]      mul_product;
    logic                   mul_ready;

    modport slave (
        input  req_valid, req_a, req_b, res_ready, mul_product, mul_ready,
        output req_ready, res_valid, res_id, res_product, res_err,
               mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, res_ready, mul_product, mul_ready,
        input  req_ready, res_valid, res_id, res_product, res_err,
               mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search just after the
// last winner; the pointer moves to the winner when update is pulsed.
module rr_arbiter #(
    parameter int  N   = 4,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic           update,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id
);

    logic [IDW-1:0] ptr;

    always_comb begin
        int   idx;
        logic found;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant[idx] = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
    end

    // Reset pointer to the last index so requester 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDW'(N - 1);
        end else if (update) begin
            ptr <= grant_id;
        end
    end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one sequential 8x8 multiplier among N_REQ requesters: arbitrate,
// pulse start, wait for ready (with watchdog) and return a tagged product.
module mult_scheduler
    import mult_sched_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int WD_W    = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    mult_sched_if.slave  bus
);

    state_t            state;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              accept;
    logic [WD_W-1:0]   wd;

    // Grant is a subset of req_valid, so any grant in IDLE is an accept.
    assign accept        = (state == IDLE) && !rst && (|grant);
    assign bus.req_ready = ((state == IDLE) && !rst) ? grant : '0;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.req_valid),
        .update   (accept),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            bus.res_valid   <= 1'b0;
            bus.res_err     <= 1'b0;
            bus.res_product <= '0;
            bus.res_id      <= '0;
            bus.mul_start   <= 1'b0;
            bus.mul_a       <= '0;
            bus.mul_b       <= '0;
            wd              <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.mul_a     <= bus.req_a[int'(grant_id)*MUL_W +: MUL_W];
                        bus.mul_b     <= bus.req_b[int'(grant_id)*MUL_W +: MUL_W];
                        bus.res_id    <= grant_id;
                        bus.mul_start <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    bus.mul_start <= 1'b0;
                    wd            <= '0;
                    state         <= BUSY;
                end
                BUSY: begin
                    // First BUSY cycle (wd == 0) ignores a possibly stale ready.
                    if ((wd != '0) && bus.mul_ready) begin
                        bus.res_product <= bus.mul_product;
                        bus.res_err     <= 1'b0;
                        bus.res_valid   <= 1'b1;
                        state           <= RESULT;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        bus.res_product <= '0;
                        bus.res_err     <= 1'b1;
                        bus.res_valid   <= 1'b1;
                        state           <= RESULT;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_scheduler.sv
// Self-checking bench for mult_scheduler with a behavioural shift-add
// multiplier model, vector table, scoreboard and corner-case sequences.
module tb_mult_scheduler;
    import mult_sched_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_sched_if #(.N_REQ(N)) bus ();

    mult_scheduler #(.N_REQ(N), .TIMEOUT(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Multiplier model: loads on start, one partial product per cycle, no reset.
    logic [7:0]  m_a, m_b;
    logic [15:0] m_acc = '0;
    logic [3:0]  m_cnt = 4'd8;
    logic        hang, stale_en, stale;

    always @(posedge clk) begin
        stale <= stale_en && bus.mul_start;
        if (bus.mul_start) begin
            m_a   <= bus.mul_a;
            m_b   <= bus.mul_b;
            m_acc <= '0;
            m_cnt <= '0;
        end else if (m_cnt < 4'd8) begin
            if (m_b[m_cnt[2:0]]) m_acc <= m_acc + ({8'd0, m_a} << m_cnt);
            m_cnt <= m_cnt + 1'b1;
        end
    end

    assign bus.mul_product = m_acc;
    assign bus.mul_ready   = hang ? 1'b0 : ((m_cnt == 4'd8) | stale);

    typedef struct {
        int          id;
        logic [15:0] prod;
        logic        err;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          id;
        logic [7:0]  a;
        logic [7:0]  b;
        int          stall;
        int          lat;
        logic        err;
    } vec_t;

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 32'(bus.req_ready), 0);
        check("rst_res_valid", 32'(bus.res_valid), 0);
        check("rst_res_err", 32'(bus.res_err), 0);
        check("rst_res_product", 32'(bus.res_product), 0);
        check("rst_res_id", 32'(bus.res_id), 0);
        check("rst_mul_start", 32'(bus.mul_start), 0);
        check("rst_mul_a", 32'(bus.mul_a), 0);
        check("rst_mul_b", 32'(bus.mul_b), 0);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            $display("FAIL %s_sb_empty: got result id %0d expected none", tag, bus.res_id);
        end else begin
            e = sbq.pop_front();
            check({tag, "_id"}, 32'(bus.res_id), 32'(e.id));
            check({tag, "_product"}, 32'(bus.res_product), 32'(e.prod));
            check({tag, "_err"}, 32'(bus.res_err), 32'(e.err));
        end
    endtask

    task automatic wait_valid(input string tag, output int k);
        k = 0;
        while (!bus.res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 32'(bus.res_valid), 1);
    endtask

    // One operation from a single requester; we start at a negedge.
    task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b,
                          input int stall, input int lat, input logic err);
        int k;
        int t;
        exp_t e;
        bus.req_a[8*id +: 8] = a;
        bus.req_b[8*id +: 8] = b;
        bus.req_valid        = 4'(1 << id);
        bus.res_ready        = (stall == 0);
        #1;
        t = 0;
        while (bus.req_ready == '0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("grant", 32'(bus.req_ready), 32'(1 << id));
        e.id   = id;
        e.prod = err ? 16'd0 : 16'(a) * 16'(b);
        e.err  = err;
        sbq.push_back(e);
        @(negedge clk);
        bus.req_valid = (stall > 0) ? 4'hF : 4'h0;
        check("mul_start_hi", 32'(bus.mul_start), 1);
        check("mul_a", 32'(bus.mul_a), 32'(a));
        check("mul_b", 32'(bus.mul_b), 32'(b));
        @(negedge clk);
        check("mul_start_lo", 32'(bus.mul_start), 0);
        k = 2;
        while (!bus.res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k - 1), 32'(lat));
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", 32'(bus.res_valid), 1);
            check("stall_product", 32'(bus.res_product), 32'(e.prod));
            check("stall_no_grant", 32'(bus.req_ready), 0);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        #1;
        check("hs_valid", 32'(bus.res_valid), 1);
        pop_compare("op");
        @(negedge clk);
        check("valid_dropped", 32'(bus.res_valid), 0);
    endtask

    vec_t vecs[5];

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        int t;
        exp_t e;
        vecs[0] = '{id: 2, a: 8'd13,  b: 8'd11,  stall: 0, lat: 10, err: 1'b0};
        vecs[1] = '{id: 3, a: 8'd255, b: 8'd255, stall: 5, lat: 10, err: 1'b0};
        vecs[2] = '{id: 0, a: 8'd0,   b: 8'd77,  stall: 0, lat: 10, err: 1'b0};
        vecs[3] = '{id: 1, a: 8'd1,   b: 8'd255, stall: 0, lat: 10, err: 1'b0};
        vecs[4] = '{id: 0, a: 8'd128, b: 8'd2,   stall: 2, lat: 10, err: 1'b0};

        rst           = 1'b1;
        hang          = 1'b0;
        stale_en      = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].stall, vecs[i].lat, vecs[i].err);

        // Fairness: all requesters hold requests; expect ids 0,1,2,3,0 after reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            bus.req_a[8*i +: 8] = 8'(i + 1);
            bus.req_b[8*i +: 8] = 8'd10;
        end
        for (int r = 0; r < 5; r++) begin
            e.id   = r % N;
            e.prod = 16'((r % N + 1) * 10);
            e.err  = 1'b0;
            sbq.push_back(e);
        end
        bus.res_ready = 1'b1;
        bus.req_valid = 4'hF;
        for (int r = 0; r < 5; r++) begin
            wait_valid("fair", k);
            pop_compare("fair");
            @(negedge clk);
        end
        bus.req_valid = '0;
        repeat (14) @(negedge clk);
        check("fair_idle", 32'(bus.res_valid), 0);

        // Reset four cycles after accept, then a fresh op with a stale ready.
        bus.req_a[8*3 +: 8] = 8'd9;
        bus.req_b[8*3 +: 8] = 8'd9;
        bus.req_valid       = 4'b1000;
        #1;
        t = 0;
        while (bus.req_ready == '0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("midrst_grant", 32'(bus.req_ready), 32'(4'b1000));
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        bus.req_valid = '0;
        rst           = 1'b0;
        stale_en      = 1'b1;
        run_op(1, 8'd6, 8'd7, 0, 10, 1'b0);
        stale_en      = 1'b0;

        // Hung multiplier: watchdog fires after 12 BUSY cycles, then recovery.
        hang = 1'b1;
        run_op(2, 8'd50, 8'd3, 0, 13, 1'b1);
        hang = 1'b0;
        run_op(3, 8'd20, 8'd12, 0, 10, 1'b0);

        check("sb_drained", 32'(sbq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
# mult_scheduler

Round-robin scheduler that shares one sequential 8×8 shift-add multiplier among `N_REQ` requesters. It arbitrates incoming operand requests, launches the multiplier with a one-cycle start pulse, waits for its ready flag and returns the 16-bit product, tagged with the requester ID, on a single valid/ready result channel. It sits between the client blocks and the multiplier; the multiplier itself is unchanged and has no reset.

## Interface
- `N_REQ`, 4: number of requesters, minimum 2.
- `ID_W`, `$clog2(N_REQ)`: width of the requester ID.
- `TIMEOUT`, 12: maximum number of BUSY cycles allowed before the multiplier is declared hung.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N_REQ: per-requester request.
- `req_a` in 8·N_REQ: multiplicand; requester i uses bits [8i+7:8i].
- `req_b` in 8·N_REQ: multiplier; same packing as `req_a`.
- `req_ready` out N_REQ: one-hot grant. A request is accepted on a cycle where `req_valid[i] & req_ready[i]`.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_id` out ID_W: index of the requester that owns the result.
- `res_product` out 16: A×B.
- `res_err` out 1: timeout flag, qualified by `res_valid`.
- `mul_start` out 1: start pulse to the multiplier.
- `mul_a` out 8: multiplicand operand to the multiplier.
- `mul_b` out 8: multiplier operand to the multiplier.
- `mul_product` in 16: product returned by the multiplier.
- `mul_ready` in 1: multiplier done flag (high when its internal counter reaches 8).

## Operation
- FSM states: IDLE → START → BUSY → RESULT → IDLE.
- **IDLE**
  - `req_ready` is the round-robin winner among the asserted `req_valid` bits, combinational from `req_valid` and the priority pointer.
  - On accept: register the winner's operands into `mul_a`/`mul_b`, register `res_id`, set the pointer to the winner, go to START.
- **START**
  - `mul_start=1` for exactly one cycle; the multiplier loads on this edge. Go to BUSY.
- **BUSY**
  - `mul_ready` is ignored in the first BUSY cycle. It may still be stale-high from a previous operation or undefined at power-up.
  - From the second BUSY cycle on, `mul_ready=1` → capture `mul_product` into `res_product`, set `res_err=0`, go to RESULT.
  - If the watchdog reaches `TIMEOUT` BUSY cycles with no qualifying ready → `res_product=0`, `res_err=1`, go to RESULT.
- **RESULT**
  - `res_valid=1`; `res_product`, `res_id` and `res_err` are held stable until `res_valid & res_ready`, then go to IDLE.
- `req_ready` is 0 in every state other than IDLE. Only one operation is in flight at a time.
- Round-robin rule: priority starts at pointer+1 and wraps modulo `N_REQ`. The reset value of the pointer is `N_REQ-1`, so requester 0 wins first.
- Arithmetic: products are unsigned. 255×255 = 65025 fits the 16-bit result; there is no overflow path.
- Reset, at any time including mid-operation: FSM → IDLE, `req_ready=0`, `res_valid=0`, `res_err=0`, `res_product=0`, `res_id=0`, `mul_start=0`, `mul_a=mul_b=0`, watchdog=0, pointer=`N_REQ-1`. The multiplier is not reset; its stale `mul_ready` is harmless because of the BUSY first-cycle rule.

## Timing
- Accept at edge E0. `mul_start` is high during the cycle E0–E1, and the multiplier loads at E1.
- The multiplier counter reaches 8 at E9, so `mul_ready` is high in the cycle after E9.
- The FSM captures the product at E10; `res_valid` is first high in the cycle after E10. Latency from accept to `res_valid` is 10 cycles.
- If `res_ready` is already high, the handshake completes at E11 and IDLE can accept again at E12. Best-case throughput is one operation per 12 cycles.
- `res_ready` held low stalls the block indefinitely in RESULT. Requests are not accepted during the stall and no data is lost.
- Request ports may hold `req_valid` high indefinitely. The accepted operands are those sampled at the accept edge.

## Structure
- Package `mult_sched_pkg` holds:
  - the state enum (IDLE, START, BUSY, RESULT);
  - `MUL_W=8`, `PROD_W=16`, `MUL_LAT=8`;
  - the default `TIMEOUT`.
- Sub-module `rr_arbiter` (parameter `N`) provides the one-hot grant from the request vector and the pointer, plus a pointer-update input. Everything else lives in `mult_scheduler`.

## Test plan
- **Single request:** reset, then requester 2 requests A=13, B=11 → `req_ready=4'b0100` for one cycle; 10 cycles later `res_valid=1`, `res_id=2`, `res_product=143`, `res_err=0`.
- **Fairness:** all four requesters hold requests continuously with A=i+1, B=10 → results in order id 0,1,2,3,0 with products 10,20,30,40,10; no requester is granted twice before the others are served.
- **Backpressure and boundary values:** A=255, B=255 with `res_ready` held low for 5 cycles → `res_product=65025` held stable throughout; no new `req_ready` until the handshake. Then A=0, B=77 → 0.
- **Reset mid-operation:** `rst` pulsed 4 cycles after accept → all outputs take their reset values next cycle. A new request from requester 1 with A=6, B=7 → 42 after 10 cycles, with a stale-high `mul_ready` ignored.
- **Timeout:** multiplier model with `mul_ready` tied to 0 → `res_valid=1`, `res_err=1`, `res_product=0` after 12 BUSY cycles; the next operation completes normally once the model is restored.
